uart_rx: RTL

//   Serial-to-parallel UART receiver; downstream counterpart of the uart_tx transmitter on the serial link.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry.
// Used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic logic even_par_ok(
        input logic [UART_DATA_BITS-1:0] data,
        input logic                      par
    );
        return ~(^data ^ par);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect.
// All flops reset to 1 (idle line) so reset never fakes a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_in,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= rx_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_sync_d & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN), mid-bit sampling,
// one-entry valid/ready holding register with sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_frame_err,
    output logic                      rx_parity_err,
    output logic                      rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic w_rx_s;
    logic w_fall;

    logic [2:0]                r_state;
    logic [CW-1:0]             r_clk_cnt;
    logic [2:0]                r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;

    logic w_tick_half;
    logic w_tick_full;
    logic w_stop_smp;
    logic w_par_ok;
    logic w_accept;
    logic w_hs;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx_in   (rx_in),
        .rx_s    (w_rx_s),
        .fall    (w_fall)
    );

    assign w_tick_half = (r_clk_cnt == HALF_M1);
    assign w_tick_full = (r_clk_cnt == FULL_M1);
    assign w_stop_smp  = (r_state == ST_STOP) && w_tick_full;

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;

    assign w_par_ok = even_par_ok(r_shift, r_par_bit);
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;

    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (w_tick_half) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick_full) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_AFTER_DATA;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick_full) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick_full) begin
                        r_clk_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clk_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if ((r_state == ST_PARITY) && w_tick_full) begin
                r_par_bit <= w_rx_s;
            end
            r_parity_err <= w_stop_smp & w_rx_s & ~w_par_ok;
        end
    end

    assign rx_parity_err = r_parity_err;
`else
    assign rx_parity_err = 1'b0;
`endif

    assign w_accept = w_stop_smp & w_rx_s & w_par_ok;
    assign w_hs     = r_valid & rx_ready;

    // A completing byte takes priority over the handshake clearing valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_smp & ~w_rx_s;
            if (w_accept) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                if (r_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else if (w_hs) begin
                    r_overrun <= 1'b0;
                end
            end else if (w_hs) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule
